// File: rtl/axi_latency_probe.sv
// axi_latency_probe: AXI-stream pass-through stage with a 2-entry skid buffer that
// measures per-packet latency (egress timer minus ingress timestamp in tuser[55:28])
// and keeps last/min/max latency, packet count, beat count and a length-error flag.
module axi_latency_probe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MAX_PKT_LEN = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [63:0]      timer,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic [127:0]     in_tuser,
  input  logic             in_tlast,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic [127:0]     out_tuser,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [27:0]      last_latency,
  output logic [27:0]      min_latency,
  output logic [27:0]      max_latency,
  output logic [31:0]      pkt_cnt,
  output logic [15:0]      last_pkt_beats,
  output logic             len_err
);

  localparam int unsigned TS_W    = 28;
  localparam int unsigned TS_LSB  = 28;
  localparam int unsigned USER_W  = 128;
  localparam int unsigned BEATS_W = 16;
  localparam int unsigned CNT_W   = 32;

  typedef struct packed {
    logic [WIDTH-1:0]  tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  typedef enum logic {IDLE, INPKT} state_e;

  // ---------------- skid buffer ----------------
  beat_t in_beat;
  beat_t out_q, out_d;
  beat_t skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q;
  logic  in_hs, out_hs;

  assign in_beat = '{tdata: in_tdata, tuser: in_tuser, tlast: in_tlast};
  assign in_hs   = in_tvalid & ready_q;
  assign out_hs  = out_valid_q & out_tready;

  // Next state of the output register and the skid entry
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_tready) begin
      if (skid_valid_q) begin
        // in_tready is low whenever the skid entry is occupied
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_hs;
        if (in_hs) out_d = in_beat;
      end
    end else if (in_hs) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  // Skid buffer registers; ready is the registered "not full"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  // ---------------- measurement ----------------
  state_e             state_q;
  logic [TS_W-1:0]    lat_q;
  logic [BEATS_W-1:0] beats_q;
  logic [TS_W-1:0]    lat_now, lat_pkt;
  logic [BEATS_W-1:0] beats_pkt;
  logic               commit;

  logic [TS_W-1:0]    last_q, min_q, max_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BEATS_W-1:0] last_beats_q;
  logic               len_err_q;

  logic               unused_timer_hi;
  assign unused_timer_hi = ^timer[63:TS_W];

  // Latency and beat count as seen by the current output beat (modulo-2^28 subtract)
  assign lat_now   = timer[TS_W-1:0] - out_q.tuser[TS_LSB +: TS_W];
  assign lat_pkt   = (state_q == IDLE) ? lat_now : lat_q;
  assign beats_pkt = (state_q == IDLE) ? BEATS_W'(1)
                   : ((beats_q == '1) ? beats_q : beats_q + BEATS_W'(1));
  assign commit    = out_hs & out_q.tlast & enable;

  // Packet FSM and statistics; clear beats a same-cycle commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      beats_q      <= '0;
      last_q       <= '0;
      min_q        <= '1;
      max_q        <= '0;
      cnt_q        <= '0;
      last_beats_q <= '0;
      len_err_q    <= 1'b0;
    end else begin
      if (out_hs) begin
        lat_q   <= lat_pkt;
        beats_q <= beats_pkt;
        state_q <= out_q.tlast ? IDLE : INPKT;
      end
      if (clear) begin
        last_q       <= '0;
        min_q        <= '1;
        max_q        <= '0;
        cnt_q        <= '0;
        last_beats_q <= '0;
        len_err_q    <= 1'b0;
      end else if (commit) begin
        last_q       <= lat_pkt;
        if (lat_pkt < min_q) min_q <= lat_pkt;
        if (lat_pkt > max_q) max_q <= lat_pkt;
        cnt_q        <= cnt_q + CNT_W'(1);
        last_beats_q <= beats_pkt;
        if (32'(beats_pkt) > MAX_PKT_LEN) len_err_q <= 1'b1;
      end
    end
  end

  assign in_tready      = ready_q;
  assign out_tdata      = out_q.tdata;
  assign out_tuser      = out_q.tuser;
  assign out_tlast      = out_q.tlast;
  assign out_tvalid     = out_valid_q;
  assign last_latency   = last_q;
  assign min_latency    = min_q;
  assign max_latency    = max_q;
  assign pkt_cnt        = cnt_q;
  assign last_pkt_beats = last_beats_q;
  assign len_err        = len_err_q;

endmodule

// File: tb/tb_axi_latency_probe.sv
// Bench for axi_latency_probe: queue-based stream model plus packet statistics model.
module tb_axi_latency_probe;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MAX_PKT_LEN = 2048;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [127:0]     user;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             clear = 1'b0;
  logic [63:0]      timer = '0;
  logic [WIDTH-1:0] in_tdata = '0;
  logic [127:0]     in_tuser = '0;
  logic             in_tlast = 1'b0;
  logic             in_tvalid = 1'b0;
  logic             in_tready;
  logic [WIDTH-1:0] out_tdata;
  logic [127:0]     out_tuser;
  logic             out_tlast;
  logic             out_tvalid;
  logic             out_tready = 1'b0;
  logic [27:0]      last_latency, min_latency, max_latency;
  logic [31:0]      pkt_cnt;
  logic [15:0]      last_pkt_beats;
  logic             len_err;

  axi_latency_probe #(.WIDTH(WIDTH), .MAX_PKT_LEN(MAX_PKT_LEN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .timer(timer),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .last_latency(last_latency), .min_latency(min_latency), .max_latency(max_latency),
    .pkt_cnt(pkt_cnt), .last_pkt_beats(last_pkt_beats), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t       exp_q[$];
  int          edges = 0;
  logic [27:0] m_last, m_min, m_max, m_lat;
  logic [31:0] m_cnt;
  logic [15:0] m_beats;
  bit          m_lenerr, m_inpkt;
  int          m_pb;
  bit          prev_stall;
  beat_t       prev_out, cur_out, got;
  bit          hs;

  task automatic model_stats_reset();
    m_last = '0; m_min = 28'hFFFFFFF; m_max = '0;
    m_cnt = '0; m_beats = '0; m_lenerr = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) edges <= edges + 1;
    else       edges <= 0;
  end

  // Per-cycle compare; model advances by the handshakes that occur at the next edge
  always @(negedge clk) begin
    cur_out = '{data: out_tdata, user: out_tuser, last: out_tlast};
    if (!reset) begin
      check("rst_in_tready", 192'(in_tready), 192'(0));
      check("rst_out_tvalid", 192'(out_tvalid), 192'(0));
      check("rst_out_beat", 192'(cur_out), 192'(0));
      check("rst_stats", 192'({last_latency, min_latency, max_latency, pkt_cnt, last_pkt_beats, len_err}),
            192'({28'd0, 28'hFFFFFFF, 28'd0, 32'd0, 16'd0, 1'b0}));
      model_stats_reset();
      exp_q.delete();
      m_inpkt = 1'b0;
      m_pb = 0;
      prev_stall = 1'b0;
    end else if (edges == 0) begin
      check("ready_before_first_edge", 192'(in_tready), 192'(0));
    end else begin
      check("in_tready", 192'(in_tready), 192'(exp_q.size() < 2));
      check("out_tvalid", 192'(out_tvalid), 192'(exp_q.size() != 0));
      if (prev_stall) check("stall_hold", 192'({out_tvalid, cur_out}), 192'({1'b1, prev_out}));
      check("last_latency", 192'(last_latency), 192'(m_last));
      check("min_latency", 192'(min_latency), 192'(m_min));
      check("max_latency", 192'(max_latency), 192'(m_max));
      check("pkt_cnt", 192'(pkt_cnt), 192'(m_cnt));
      check("last_pkt_beats", 192'(last_pkt_beats), 192'(m_beats));
      check("len_err", 192'(len_err), 192'(m_lenerr));

      hs = out_tvalid && out_tready && (exp_q.size() != 0);
      got = '0;
      if (hs) begin
        got = exp_q.pop_front();
        check("out_beat", 192'(cur_out), 192'(got));
        if (!m_inpkt) begin
          m_lat = 28'(timer[27:0] - got.user[55:28]);
          m_pb = 1;
        end else begin
          m_pb++;
        end
        m_inpkt = !got.last;
      end
      if (clear) begin
        model_stats_reset();
      end else if (hs && got.last && enable) begin
        m_last = m_lat;
        if (m_lat < m_min) m_min = m_lat;
        if (m_lat > m_max) m_max = m_lat;
        m_beats = (m_pb > 65535) ? 16'hFFFF : 16'(m_pb);
        m_cnt = m_cnt + 32'd1;
        if (m_pb > int'(MAX_PKT_LEN)) m_lenerr = 1'b1;
      end
      if (in_tvalid && in_tready) exp_q.push_back('{data: in_tdata, user: in_tuser, last: in_tlast});
      prev_stall = out_tvalid && !out_tready;
      prev_out = cur_out;
    end
  end

  // ---------------- stimulus ----------------
  bit timer_run = 1'b1;
  bit rnd_ctl = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (timer_run) timer = timer + 64'($urandom_range(1, 4));
  endtask

  task automatic send_pkt(input int len, input bit fix_ts, input logic [27:0] ts,
                          input int rdy_pct, input int gap_pct);
    int i = 0;
    int guard = 0;
    bit acc;
    logic [127:0] u;
    while (i < len) begin
      if (!in_tvalid && ($urandom_range(0, 99) >= gap_pct)) begin
        u = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (fix_ts) u[55:28] = ts;
        in_tdata  = $urandom();
        in_tuser  = u;
        in_tlast  = (i == len - 1);
        in_tvalid = 1'b1;
      end
      out_tready = ($urandom_range(0, 99) < rdy_pct);
      if (rnd_ctl) begin
        enable = ($urandom_range(0, 99) < 75);
        clear  = ($urandom_range(0, 99) < 3);
      end
      acc = in_tvalid && in_tready;
      tick();
      if (acc) begin
        in_tvalid = 1'b0;
        i++;
      end
      guard++;
      if (guard > 20000) begin
        check("send_timeout", 192'(i), 192'(len));
        break;
      end
    end
    in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    out_tready = 1'b1;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) check("drain_timeout", 192'(exp_q.size()), 192'(0));
    repeat (2) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // 1: reset release, no traffic
    repeat (3) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t1_in_tready", 192'(in_tready), 192'(1));
    check("t1_out_tvalid", 192'(out_tvalid), 192'(0));
    check("t1_min", 192'(min_latency), 192'(28'hFFFFFFF));
    check("t1_max", 192'(max_latency), 192'(0));

    // 2: 4-beat packet, ts=100, egress timer 130
    timer_run = 1'b0;
    timer = 64'd130;
    tick();
    send_pkt(4, 1'b1, 28'd100, 100, 0);
    drain();
    @(negedge clk);
    check("t2_last", 192'(last_latency), 192'(28'd30));
    check("t2_min", 192'(min_latency), 192'(28'd30));
    check("t2_max", 192'(max_latency), 192'(28'd30));
    check("t2_cnt", 192'(pkt_cnt), 192'(32'd1));
    check("t2_beats", 192'(last_pkt_beats), 192'(16'd4));
    check("t2_model_last", 192'(m_last), 192'(28'd30));

    // 3: timestamp wrap
    timer = 64'h1234_5678_0000_0010;
    tick();
    send_pkt(2, 1'b1, 28'hFFFFFF0, 100, 0);
    drain();
    @(negedge clk);
    check("t3_last_wrap", 192'(last_latency), 192'(28'h20));
    check("t3_max", 192'(max_latency), 192'(28'h20));
    check("t3_model_last", 192'(m_last), 192'(28'h20));

    // 4: random backpressure and gaps, 20 packets
    timer_run = 1'b1;
    pulse_clear();
    for (int p = 0; p < 20; p++) send_pkt(int'($urandom_range(1, 99)), 1'b0, 28'd0, 50, 20);
    drain();
    @(negedge clk);
    check("t4_cnt", 192'(pkt_cnt), 192'(32'd20));

    // 5: over-length packet sets a sticky len_err
    pulse_clear();
    send_pkt(int'(MAX_PKT_LEN) + 1, 1'b0, 28'd0, 100, 0);
    drain();
    @(negedge clk);
    check("t5_len_err", 192'(len_err), 192'(1));
    check("t5_beats", 192'(last_pkt_beats), 192'(16'd2049));
    send_pkt(3, 1'b0, 28'd0, 100, 0);
    drain();
    @(negedge clk);
    check("t5_len_err_sticky", 192'(len_err), 192'(1));
    check("t5_cnt", 192'(pkt_cnt), 192'(32'd2));
    tick();
    pulse_clear();
    @(negedge clk);
    check("t5_clear_len_err", 192'(len_err), 192'(0));
    check("t5_clear_cnt", 192'(pkt_cnt), 192'(32'd0));

    // 6: clear on the commit cycle, then a packet with enable=0
    tick();
    send_pkt(3, 1'b0, 28'd0, 100, 0);
    drain();
    @(negedge clk);
    check("t6_cnt_before", 192'(pkt_cnt), 192'(32'd1));
    tick();
    out_tready = 1'b0;
    in_tdata  = $urandom();
    in_tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_tlast  = 1'b1;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    tick();
    out_tready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("t6_clear_wins_cnt", 192'(pkt_cnt), 192'(32'd0));
    check("t6_clear_wins_min", 192'(min_latency), 192'(28'hFFFFFFF));
    tick();
    enable = 1'b0;
    send_pkt(5, 1'b0, 28'd0, 60, 10);
    drain();
    enable = 1'b1;
    @(negedge clk);
    check("t6_disabled_cnt", 192'(pkt_cnt), 192'(32'd0));
    check("t6_disabled_beats", 192'(last_pkt_beats), 192'(16'd0));

    // 7: random enable/clear over random traffic
    tick();
    rnd_ctl = 1'b1;
    for (int p = 0; p < 12; p++) send_pkt(int'($urandom_range(1, 40)), 1'b0, 28'd0, 70, 30);
    rnd_ctl = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    drain();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
